// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings, loaded-flag and button indices.
package alu_pkg;

  localparam int ALU_NB_DATA   = 8;
  localparam int ALU_NB_OPCODE = 6;

  typedef enum logic [5:0] {
    OP_SRL = 6'b000010,
    OP_SRA = 6'b000011,
    OP_ADD = 6'b100000,
    OP_SUB = 6'b100010,
    OP_AND = 6'b100100,
    OP_OR  = 6'b100101,
    OP_XOR = 6'b100110,
    OP_NOR = 6'b100111
  } alu_opcode_e;

  // o_loaded bit positions, ordered {opcode, op2, op1}
  localparam int NB_LOADED = 3;
  localparam int LD_OP1    = 0;
  localparam int LD_OP2    = 1;
  localparam int LD_OPCODE = 2;

  localparam int NB_BTN     = 4;
  localparam int BTN_OP1    = 0;
  localparam int BTN_OP2    = 1;
  localparam int BTN_OPCODE = 2;
  localparam int BTN_CLEAR  = 3;

  function automatic logic all_loaded(input logic [NB_LOADED-1:0] flags);
    return &flags;
  endfunction

endpackage

// File: rtl/alu_input_loader_if.sv
// Board-side bundle of the operand loader: raw switches/buttons in, registered ALU operands out.
interface alu_input_loader_if
  import alu_pkg::*;
#(
  parameter int NB_SW     = 8,
  parameter int NB_DATA   = ALU_NB_DATA,
  parameter int NB_OPCODE = ALU_NB_OPCODE
);

  logic        [NB_SW-1:0]     i_sw;
  logic                        i_btn_op1;
  logic                        i_btn_op2;
  logic                        i_btn_opcode;
  logic                        i_btn_clear;
  logic signed [NB_DATA-1:0]   o_op_1;
  logic signed [NB_DATA-1:0]   o_op_2;
  logic        [NB_OPCODE-1:0] o_opcode;
  logic        [NB_LOADED-1:0] o_loaded;
  logic                        o_valid;

  modport slave (
    input  i_sw, i_btn_op1, i_btn_op2, i_btn_opcode, i_btn_clear,
    output o_op_1, o_op_2, o_opcode, o_loaded, o_valid
  );

  modport master (
    output i_sw, i_btn_op1, i_btn_op2, i_btn_opcode, i_btn_clear,
    input  o_op_1, o_op_2, o_opcode, o_loaded, o_valid
  );

endinterface

// File: rtl/btn_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-FF sync, optional debounce, rising-edge detect.
// Debounce filter is present only when ALU_INPUT_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync_p0;
  logic r_sync_p1;
  logic r_lvl_p3;
  logic w_lvl;

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  // stage p0/p1: metastability synchronizer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_btn;
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef ALU_INPUT_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt_p2;
  logic             r_deb_p2;

  // stage p2: level accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_p2 <= '0;
      r_deb_p2 <= 1'b0;
    end else if (r_sync_p1 == r_deb_p2) begin
      r_cnt_p2 <= '0;
    end else if (r_cnt_p2 == CNT_LAST) begin
      r_cnt_p2 <= '0;
      r_deb_p2 <= ~r_deb_p2;
    end else begin
      r_cnt_p2 <= r_cnt_p2 + 1'b1;
    end
  end

  assign w_lvl = r_deb_p2;
`else
  assign w_lvl = r_sync_p1;
`endif

  // stage p3: previous level for rising-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lvl_p3 <= 1'b0;
    end else begin
      r_lvl_p3 <= w_lvl;
    end
  end

  assign o_pulse = w_lvl & ~r_lvl_p3;

endmodule

// File: rtl/alu_input_loader.sv
// Captures ALU operands/opcode from slide switches on button presses and holds them for the ALU.
// Define ALU_INPUT_DEBOUNCE_EN for the board build (debounce filter on every button).
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int          NB_DATA         = ALU_NB_DATA,
  parameter int          NB_OPCODE       = ALU_NB_OPCODE,
  parameter int          NB_SW           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
)(
  input  logic                i_clk,
  input  logic                i_rst_n,
  alu_input_loader_if.slave   io
);

  if ((NB_SW < NB_DATA) || (NB_SW < NB_OPCODE)) begin : g_bad_cfg
    $error("alu_input_loader: NB_SW must cover both NB_DATA and NB_OPCODE");
  end

  logic        [NB_BTN-1:0]    w_btn_raw;
  logic        [NB_BTN-1:0]    w_pulse;
  logic        [NB_SW-1:0]     r_sw_p0;
  logic        [NB_SW-1:0]     r_sw_p1;
  logic signed [NB_DATA-1:0]   r_op_1;
  logic signed [NB_DATA-1:0]   r_op_2;
  logic        [NB_OPCODE-1:0] r_opcode;
  logic        [NB_LOADED-1:0] r_loaded;
  logic                        r_valid;
  logic        [NB_LOADED-1:0] w_loaded_nxt;
  logic                        w_ld_op1;
  logic                        w_ld_op2;
  logic                        w_ld_opcode;
  logic                        w_clr;

  assign w_btn_raw[BTN_OP1]    = io.i_btn_op1;
  assign w_btn_raw[BTN_OP2]    = io.i_btn_op2;
  assign w_btn_raw[BTN_OPCODE] = io.i_btn_opcode;
  assign w_btn_raw[BTN_CLEAR]  = io.i_btn_clear;

  for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (w_btn_raw[g]),
      .o_pulse (w_pulse[g])
    );
  end

  // clear dominates: a load in the same cycle as clear is dropped
  assign w_clr       = w_pulse[BTN_CLEAR];
  assign w_ld_op1    = w_pulse[BTN_OP1]    & ~w_clr;
  assign w_ld_op2    = w_pulse[BTN_OP2]    & ~w_clr;
  assign w_ld_opcode = w_pulse[BTN_OPCODE] & ~w_clr;

  // stage p0/p1: switch synchronizer, sampled by whichever load fires
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_p0 <= '0;
      r_sw_p1 <= '0;
    end else begin
      r_sw_p0 <= io.i_sw;
      r_sw_p1 <= r_sw_p0;
    end
  end

  always_comb begin
    w_loaded_nxt = r_loaded;
    if (w_clr) begin
      w_loaded_nxt = '0;
    end else begin
      if (w_ld_op1)    w_loaded_nxt[LD_OP1]    = 1'b1;
      if (w_ld_op2)    w_loaded_nxt[LD_OP2]    = 1'b1;
      if (w_ld_opcode) w_loaded_nxt[LD_OPCODE] = 1'b1;
    end
  end

  // output stage: operand registers with flags and valid updated on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_1   <= '0;
      r_op_2   <= '0;
      r_opcode <= '0;
      r_loaded <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_loaded <= w_loaded_nxt;
      r_valid  <= all_loaded(w_loaded_nxt);
      if (w_clr) begin
        r_op_1   <= '0;
        r_op_2   <= '0;
        r_opcode <= '0;
      end else begin
        if (w_ld_op1)    r_op_1   <= $signed(r_sw_p1[NB_DATA-1:0]);
        if (w_ld_op2)    r_op_2   <= $signed(r_sw_p1[NB_DATA-1:0]);
        if (w_ld_opcode) r_opcode <= r_sw_p1[NB_OPCODE-1:0];
      end
    end
  end

  assign io.o_op_1   = r_op_1;
  assign io.o_op_2   = r_op_2;
  assign io.o_opcode = r_opcode;
  assign io.o_loaded = r_loaded;
  assign io.o_valid  = r_valid;

endmodule

// File: tb/tb_alu_input_loader.sv
// Scoreboard bench for alu_input_loader: directed presses push expected snapshots, a monitor checks changes.
`timescale 1ns/1ps
module tb_alu_input_loader;
  import alu_pkg::*;

  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;
  localparam int NB_SW     = 8;
  localparam int DEB       = 16;
`ifdef ALU_INPUT_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif
  localparam int GAP  = LAT + 12;
  localparam int HOLD = LAT + 6;

  localparam logic [3:0] M_OP1 = 4'b0001;
  localparam logic [3:0] M_OP2 = 4'b0010;
  localparam logic [3:0] M_OPC = 4'b0100;
  localparam logic [3:0] M_CLR = 4'b1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_input_loader_if #(.NB_SW(NB_SW), .NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE)) bus ();

  alu_input_loader #(
    .NB_DATA         (NB_DATA),
    .NB_OPCODE       (NB_OPCODE),
    .NB_SW           (NB_SW),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          op1;
    int          op2;
    int          opc;
    logic [2:0]  ld;
    logic        vld;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  logic [25:0] prev_snap = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, $signed(got), $signed(req));
    end
  endtask

  always @(negedge clk) begin
    logic [25:0] snap;
    exp_t        e;
    snap = {bus.o_op_1, bus.o_op_2, bus.o_opcode, bus.o_loaded, bus.o_valid};
    if (mon_en && (snap !== prev_snap)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, snap);
      end else begin
        e = q.pop_front();
        chk("load_cycle", cyc, e.cyc);
        chk("op_1",   $signed(bus.o_op_1), e.op1);
        chk("op_2",   $signed(bus.o_op_2), e.op2);
        chk("opcode", {26'd0, bus.o_opcode}, e.opc);
        chk("loaded", {29'd0, bus.o_loaded}, {29'd0, e.ld});
        chk("valid",  {31'd0, bus.o_valid},  {31'd0, e.vld});
      end
    end
    prev_snap = snap;
  end

  task automatic set_btns(input logic [3:0] m);
    {bus.i_btn_clear, bus.i_btn_opcode, bus.i_btn_op2, bus.i_btn_op1} = m;
  endtask

  task automatic push_exp(input int at, input int e1, input int e2, input int e3,
                          input logic [2:0] eld, input logic ev);
    exp_t e;
    e.cyc = at; e.op1 = e1; e.op2 = e2; e.opc = e3; e.ld = eld; e.vld = ev;
    q.push_back(e);
  endtask

  // Pin rises before edge k = cyc+1; a load is expected at edge k+LAT.
  // Switches are inverted mid-hold so a repeated pulse would show up as a change.
  task automatic press(input logic [3:0] m, input logic [7:0] sw, input int hold, input bit load,
                       input int e1, input int e2, input int e3, input logic [2:0] eld, input logic ev);
    @(negedge clk);
    bus.i_sw = sw;
    repeat (4) @(negedge clk);
    set_btns(m);
    if (load) push_exp(cyc + 1 + LAT, e1, e2, e3, eld, ev);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (i == LAT + 3) bus.i_sw = ~sw;
    end
    @(negedge clk);
    set_btns(4'b0000);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_op_1"},   $signed(bus.o_op_1), 0);
    chk({tag, "_op_2"},   $signed(bus.o_op_2), 0);
    chk({tag, "_opcode"}, {26'd0, bus.o_opcode}, 0);
    chk({tag, "_loaded"}, {29'd0, bus.o_loaded}, 0);
    chk({tag, "_valid"},  {31'd0, bus.o_valid}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_sw = '0;
    set_btns(4'b0000);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // full load: 5, -3, ADD
    press(M_OP1, 8'h05, HOLD, 1'b1,   5,  0,    0, 3'b001, 1'b0);
    press(M_OP2, 8'hFD, HOLD, 1'b1,   5, -3,    0, 3'b011, 1'b0);
    press(M_OPC, 8'h20, HOLD, 1'b1,   5, -3, 6'h20, 3'b111, 1'b1);
    chk("alu_add_result", $signed(bus.o_op_1) + $signed(bus.o_op_2), 2);

    // reload while valid
    press(M_OPC, 8'h22, HOLD, 1'b1,   5, -3, 6'h22, 3'b111, 1'b1);
    // long hold: one load only, none on release
    press(M_OP1, 8'h11, 50,   1'b1,  17, -3, 6'h22, 3'b111, 1'b1);
    // clear beats a simultaneous load
    press(M_CLR | M_OP1, 8'h44, HOLD, 1'b1, 0, 0, 0, 3'b000, 1'b0);
    // two loads in one cycle
    press(M_OP1 | M_OP2, 8'h7F, HOLD, 1'b1, 127, 127, 0, 3'b011, 1'b0);
    press(M_OPC, 8'h24, HOLD, 1'b1, 127, 127, 6'h24, 3'b111, 1'b1);
    press(M_CLR, 8'h99, HOLD, 1'b1,   0,   0,     0, 3'b000, 1'b0);

    // asynchronous reset mid-operation, op2 held through release
    press(M_OP1, 8'h09, HOLD, 1'b1,   9,   0,     0, 3'b001, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    bus.i_sw = 8'h0A;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    bus.i_btn_op2 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_exp(cyc + 1 + LAT, 0, 10, 0, 3'b010, 1'b0);
    mon_en = 1'b1;
    repeat (HOLD) @(negedge clk);
    bus.i_btn_op2 = 1'b0;
    repeat (GAP) @(negedge clk);

`ifdef ALU_INPUT_DEBOUNCE_EN
    // short glitch is filtered out
    press(M_OP1, 8'h55, 10, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    // 20-cycle press loads at k+2+DEB
    press(M_OPC, 8'h26, 20, 1'b1, 0, 10, 6'h26, 3'b110, 1'b0);
    // chatter then stable high: one load timed from the last rise
    @(negedge clk);
    bus.i_sw = 8'h66;
    repeat (4) @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      bus.i_btn_op1 = 1'b1;
      repeat (3) @(negedge clk);
      bus.i_btn_op1 = 1'b0;
      repeat (3) @(negedge clk);
    end
    bus.i_btn_op1 = 1'b1;
    push_exp(cyc + 1 + LAT, 102, 10, 6'h26, 3'b111, 1'b1);
    repeat (30) @(negedge clk);
    bus.i_btn_op1 = 1'b0;
    repeat (GAP) @(negedge clk);
`endif

    for (int w = 0; w < 200 && q.size() != 0; w++) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL pending_load got=no change required=change at cyc %0d", e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
